lc3b_fetch_unit: RTL and testbench
==================================

# lc3b_fetch_unit

Instruction-fetch stage of the pipelined LC-3b core, directly upstream of the IF/ID register and the decode/control ROM. Owns the PC and drives the instruction-side cache port with a held-until-response read handshake. Buffers one fetched instruction with its PC until decode accepts it. Takes control-flow redirects from later stages, discarding any in-flight fetch that a redirect makes stale.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.

- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_address  out  16  fetch address (lc3b_word); equals pc while a request is open.
- imem_read  out  1  fetch request; held high with stable address until imem_resp.
- imem_resp  in  1  single-cycle response strobe from I-cache.
- imem_rdata  in  16  instruction word; valid only with imem_resp.
- stall  in  1  downstream not accepting (inverse of if_id_enable).
- redirect  in  1  single-cycle redirect request (taken branch, JMP/JSR/TRAP).
- redirect_pc  in  16  new fetch PC; sampled with redirect.
- if_valid  out  1  output buffer holds a valid instruction.
- if_instr  out  16  buffered instruction.
- if_pc  out  16  address of if_instr.
- if_npc  out  16  if_pc + 2, modulo 2^16.

## Operation
- Registers:
  - pc: next fetch address.
  - state: RUN or DISCARD.
  - pend_pc: redirect target held while discarding.
  - Output buffer: if_valid, if_instr, if_pc.
- Consume: the buffer is consumed in any cycle where if_valid=1 and stall=0.
- imem_read:
  - RUN: asserted when (!if_valid || !stall).
  - DISCARD: asserted unconditionally.
  - Forced 0 while reset is high.
  - Invariant: once asserted, it stays asserted until imem_resp, because only a response refills the buffer.
- RUN, imem_resp=1, redirect=0:
  - buffer <= {1, imem_rdata, pc}.
  - pc <= pc+2, wrapping FFFE→0000.
- RUN, consume with no imem_resp: if_valid <= 0.
- redirect=1 in RUN:
  - Buffer flushed (if_valid <= 0).
  - A same-cycle imem_resp is dropped.
  - If a request is open without a response this cycle (imem_read=1, imem_resp=0): pend_pc <= redirect_pc, state <= DISCARD; pc is unchanged so the open address stays stable.
  - Otherwise: pc <= redirect_pc, stay in RUN.
- DISCARD:
  - Buffer stays empty.
  - redirect=1 overwrites pend_pc; the latest redirect wins.
  - On imem_resp: data dropped, pc <= pend_pc (or redirect_pc if redirect is also high that cycle), state <= RUN.
- Priority: reset > redirect > response > consume. stall never blocks a redirect.
- redirect_pc bit 0 is ignored; pc[0] is forced to 0.

## Timing
- Reset values:
  - pc = RESET_PC, state = RUN, pend_pc = 0.
  - if_valid = 0, if_instr = 0, if_pc = 0, if_npc = 2.
  - imem_read = 0 while reset is asserted.
- First request: imem_read rises in the first cycle after reset deasserts, with imem_address = RESET_PC.
- Latency: response in cycle n gives if_valid=1 in cycle n+1.
- Throughput: with 1-cycle cache hits and stall=0, one instruction per cycle (buffer consumed and refilled in the same cycle).
- Stall with a full buffer: no new request starts. An already-open request completes into the empty buffer.
- Redirect latency: the first request at redirect_pc is issued in cycle n+1 (RUN), or in the cycle after the discarded response (DISCARD).
- Reset mid-request: the request is abandoned and all state returns to reset values. The I-cache is reset by the same signal.

## Structure
- lc3b_types gains:
  - fetch_state_t enum {FETCH_RUN, FETCH_DISCARD}.
  - PC increment constant 16'd2.
  - Reuse lc3b_word for all 16-bit buses.
- Sub-module fetch_out_buf: valid/instr/pc register with load, flush and consume inputs. Keeps the flush/refill priority in one place.
- The FSM and pc/pend_pc registers live in the top module.

## Test plan
- Reset release, cache answers every cycle, stall=0:
  - if_pc sequence 0000, 0002, 0004 on consecutive cycles.
  - imem_read continuously high.
- Buffer full, stall held 3 cycles:
  - imem_read low for all 3 cycles; if_instr/if_pc stable.
  - Next fetch issues the cycle stall drops.
- Redirect to 0x3000 while a 4-cycle miss at 0x0010 is open:
  - imem_address stays 0x0010 until the response; that data never appears.
  - Next request is at 0x3000.
- Redirect to 0x4000 coincident with imem_resp: response dropped, if_valid=0 next cycle, next request at 0x4000.
- Two redirects (0x5000, then 0x6000) during DISCARD: fetch resumes at 0x6000.
- pc=FFFE fetched: if_npc=0000 and the next request is at 0000.
- Async reset asserted mid-miss: imem_read drops immediately and all outputs take reset values without a clock edge.

Source files
------------

// File: rtl/lc3b_fetch_unit_pkg.sv
// Shared types for the LC-3b fetch stage: word type, fetch FSM states and PC step.
package lc3b_fetch_unit_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic {
        FETCH_RUN     = 1'b0,
        FETCH_DISCARD = 1'b1
    } fetch_state_t;

    localparam lc3b_word PC_INC = 16'd2;

endpackage

// File: rtl/lc3b_fetch_unit_fetch_out_buf.sv
// One-entry instruction buffer between fetch and decode.
// Priority is flush > load > consume, so a redirect always wins over a refill.
module lc3b_fetch_unit_fetch_out_buf
    import lc3b_fetch_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_load,
    input  logic     i_flush,
    input  logic     i_consume,
    input  lc3b_word i_instr,
    input  lc3b_word i_pc,
    output logic     o_valid,
    output lc3b_word o_instr,
    output lc3b_word o_pc
);

    logic     r_valid;
    lc3b_word r_instr;
    lc3b_word r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction fetch: owns the PC, drives the I-cache read handshake and
// drops responses that a redirect has made stale.
module lc3b_fetch_unit
    import lc3b_fetch_unit_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     reset,
    output lc3b_word imem_address,
    output logic     imem_read,
    input  logic     imem_resp,
    input  lc3b_word imem_rdata,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output logic     if_valid,
    output lc3b_word if_instr,
    output lc3b_word if_pc,
    output lc3b_word if_npc
);

    fetch_state_t r_state, w_state_nxt;
    lc3b_word     r_pc, w_pc_nxt;
    lc3b_word     r_pend_pc, w_pend_nxt;
    lc3b_word     w_redir_pc;
    logic         w_req, w_load, w_flush, w_consume;

    assign w_redir_pc = redirect_pc & 16'hFFFE;

    // Once raised, w_req can only fall after a response: in RUN an empty
    // buffer keeps it high, and a consume empties the buffer.
    assign w_req        = (r_state == FETCH_DISCARD) || !if_valid || !stall;
    assign imem_read    = w_req && !reset;
    assign imem_address = r_pc;

    assign w_load    = (r_state == FETCH_RUN) && imem_resp && !redirect;
    assign w_flush   = redirect || (r_state == FETCH_DISCARD);
    assign w_consume = if_valid && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH_RUN;
            r_pc      <= RESET_PC;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_pc;
        case (r_state)
            FETCH_RUN: begin
                if (redirect) begin
                    // An open request must keep its address until answered.
                    if (w_req && !imem_resp) begin
                        w_pend_nxt  = w_redir_pc;
                        w_state_nxt = FETCH_DISCARD;
                    end else begin
                        w_pc_nxt = w_redir_pc;
                    end
                end else if (imem_resp) begin
                    w_pc_nxt = r_pc + PC_INC;
                end
            end
            FETCH_DISCARD: begin
                if (redirect) begin
                    w_pend_nxt = w_redir_pc;
                end
                if (imem_resp) begin
                    w_pc_nxt    = redirect ? w_redir_pc : r_pend_pc;
                    w_state_nxt = FETCH_RUN;
                end
            end
            default: w_state_nxt = FETCH_RUN;
        endcase
    end

    lc3b_fetch_unit_fetch_out_buf u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_flush   (w_flush),
        .i_consume (w_consume),
        .i_instr   (imem_rdata),
        .i_pc      (r_pc),
        .o_valid   (if_valid),
        .o_instr   (if_instr),
        .o_pc      (if_pc)
    );

    assign if_npc = if_pc + PC_INC;

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Bench for lc3b_fetch_unit: cycle-stepped I-cache stub with a scoreboard of
// accepted responses, compared as decode consumes the buffer.
module tb_lc3b_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imem_address;
    logic        imem_read;
    logic        imem_resp = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_npc;

    int checks = 0;
    int failures = 0;

    logic [31:0] sb[$];
    logic        s_valid, s_read, s_resp;
    logic [15:0] s_pc, s_instr, s_npc, s_addr;

    lc3b_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_npc       (if_npc)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] f_mem(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // One clock cycle: drive control, sample outputs, answer the open request
    // if asked, push accepted responses, advance to just after the next edge.
    task automatic step(input bit st, input bit rd, input logic [15:0] rpc,
                        input bit rsp, input bit keep);
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        imem_resp = 1'b0;
        #1;
        s_valid = if_valid;
        s_pc    = if_pc;
        s_instr = if_instr;
        s_npc   = if_npc;
        s_read  = imem_read;
        s_addr  = imem_address;
        imem_resp  = rsp && imem_read;
        imem_rdata = imem_resp ? f_mem(imem_address) : 16'hDEAD;
        s_resp = imem_resp;
        if (imem_resp && keep) sb.push_back({imem_address, f_mem(imem_address)});
        @(posedge clk);
        #1;
        imem_resp = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        imem_resp = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", imem_read); end
        exp = {16'h0000, 16'h0000};
        checks++; if ({if_pc, if_instr} !== exp) begin failures++; $display("FAIL rst_buf got=%h exp=%h", {if_pc, if_instr}, exp); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (if_npc !== 16'h0002) begin failures++; $display("FAIL rst_npc got=%h exp=0002", if_npc); end
        reset = 1'b0;
        #1;
        checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin
            failures++; $display("FAIL first_req got=%b/%h exp=1/0000", imem_read, imem_address);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        int k = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
            checks++; if (s_read !== 1'b1) begin failures++; $display("FAIL stream_read cyc=%0d got=%b exp=1", i, s_read); end
            checks++; if (s_valid !== (i > 0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, s_valid, (i > 0)); end
            if (s_valid) begin
                checks++; if (s_pc !== 16'(2 * k)) begin failures++; $display("FAIL stream_pc got=%h exp=%h", s_pc, 16'(2 * k)); end
                checks++; if (s_npc !== 16'(2 * k + 2)) begin failures++; $display("FAIL stream_npc got=%h exp=%h", s_npc, 16'(2 * k + 2)); end
                if (sb.size() == 0) begin checks++; failures++; $display("FAIL stream_sb_empty got=0 exp=1"); end
                else begin
                    e = sb.pop_front();
                    checks++; if ({s_pc, s_instr} !== e) begin failures++; $display("FAIL stream_sb got=%h exp=%h", {s_pc, s_instr}, e); end
                end
                k++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            checks++; if (s_read !== 1'b0) begin failures++; $display("FAIL stall_read cyc=%0d got=%b exp=0", i, s_read); end
            checks++; if ({s_valid, s_pc, s_instr} !== {1'b1, 16'h000A, f_mem(16'h000A)}) begin
                failures++; $display("FAIL stall_hold got=%b/%h/%h exp=1/000a/%h", s_valid, s_pc, s_instr, f_mem(16'h000A));
            end
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++; if (s_read !== 1'b1 || s_addr !== 16'h000C) begin
            failures++; $display("FAIL stall_release got=%b/%h exp=1/000c", s_read, s_addr);
        end
        e = sb.size() > 0 ? sb.pop_front() : 32'hFFFF_FFFF;
        checks++; if ({s_pc, s_instr} !== e) begin failures++; $display("FAIL stall_sb got=%h exp=%h", {s_pc, s_instr}, e); end
    endtask

    task automatic test_redirect_miss();
        logic [31:0] e;
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        void'(sb.pop_front());
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        void'(sb.pop_front());
        checks++; if (s_addr !== 16'h0010) begin failures++; $display("FAIL miss_addr got=%h exp=0010", s_addr); end
        step(1'b0, 1'b1, 16'h3000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0, (i == 2), 1'b0);
            checks++; if (s_read !== 1'b1 || s_addr !== 16'h0010 || s_valid !== 1'b0) begin
                failures++; $display("FAIL miss_hold cyc=%0d got=%b/%h/%b exp=1/0010/0", i, s_read, s_addr, s_valid);
            end
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++; if (s_valid !== 1'b0 || s_read !== 1'b1 || s_addr !== 16'h3000) begin
            failures++; $display("FAIL miss_resume got=%b/%b/%h exp=0/1/3000", s_valid, s_read, s_addr);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        e = sb.size() > 0 ? sb.pop_front() : 32'hFFFF_FFFF;
        checks++; if (s_valid !== 1'b1 || {s_pc, s_instr} !== e) begin
            failures++; $display("FAIL miss_sb got=%b/%h exp=1/%h", s_valid, {s_pc, s_instr}, e);
        end
    endtask

    task automatic test_redirect_resp();
        logic [31:0] e;
        step(1'b0, 1'b1, 16'h4000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++; if (s_valid !== 1'b0 || s_read !== 1'b1 || s_addr !== 16'h4000) begin
            failures++; $display("FAIL redir_resp got=%b/%b/%h exp=0/1/4000", s_valid, s_read, s_addr);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        e = sb.size() > 0 ? sb.pop_front() : 32'hFFFF_FFFF;
        checks++; if ({s_pc, s_instr} !== e) begin failures++; $display("FAIL redir_resp_sb got=%h exp=%h", {s_pc, s_instr}, e); end
    endtask

    task automatic test_double_redirect();
        step(1'b0, 1'b1, 16'h5000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h6001, 1'b0, 1'b0);
        checks++; if (s_addr !== 16'h4002) begin failures++; $display("FAIL dbl_hold got=%h exp=4002", s_addr); end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++; if (s_valid !== 1'b0 || s_addr !== 16'h6000) begin
            failures++; $display("FAIL dbl_resume got=%b/%h exp=0/6000", s_valid, s_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        step(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++; if (s_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_req got=%h exp=fffe", s_addr); end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        checks++; if (s_pc !== 16'hFFFE || s_npc !== 16'h0000) begin
            failures++; $display("FAIL wrap_npc got=%h/%h exp=fffe/0000", s_pc, s_npc);
        end
        checks++; if (s_addr !== 16'h0000) begin failures++; $display("FAIL wrap_next got=%h exp=0000", s_addr); end
        void'(sb.pop_front());
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        e = sb.size() > 0 ? sb.pop_front() : 32'hFFFF_FFFF;
        checks++; if ({s_pc, s_instr} !== e) begin failures++; $display("FAIL wrap_sb got=%h exp=%h", {s_pc, s_instr}, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        bit st, rsp, prev_open;
        logic [15:0] prev_addr;
        prev_open = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < 60; i++) begin
            st  = ($urandom % 4) == 0;
            rsp = ($urandom % 2) == 0;
            step(st, 1'b0, 16'h0, rsp, 1'b1);
            checks++; if (s_read !== (!s_valid || !st)) begin
                failures++; $display("FAIL b2b_read cyc=%0d got=%b exp=%b", i, s_read, (!s_valid || !st));
            end
            if (prev_open) begin
                checks++; if (s_read !== 1'b1 || s_addr !== prev_addr) begin
                    failures++; $display("FAIL b2b_hold cyc=%0d got=%b/%h exp=1/%h", i, s_read, s_addr, prev_addr);
                end
            end
            if (s_valid && !st) begin
                e = sb.size() > 0 ? sb.pop_front() : 32'hFFFF_FFFF;
                checks++; if ({s_pc, s_instr} !== e) begin failures++; $display("FAIL b2b_sb cyc=%0d got=%h exp=%h", i, {s_pc, s_instr}, e); end
            end
            prev_open = s_read && !s_resp;
            prev_addr = s_addr;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        stall = 1'b0;
        imem_resp = 1'b0;
        #1;
        checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0006 || if_valid !== 1'b1) begin
            failures++; $display("FAIL ares_pre got=%b/%h/%b exp=1/0006/1", imem_read, imem_address, if_valid);
        end
        reset = 1'b1;
        #1;
        checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL ares_read got=%b exp=0", imem_read); end
        checks++; if ({if_valid, if_pc, if_instr, if_npc, imem_address} !== {1'b0, 16'h0, 16'h0, 16'h2, 16'h0}) begin
            failures++; $display("FAIL ares_outs got=%b/%h/%h/%h/%h exp=0/0000/0000/0002/0000", if_valid, if_pc, if_instr, if_npc, imem_address);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin
            failures++; $display("FAIL ares_restart got=%b/%h exp=1/0000", imem_read, imem_address);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_miss();
        test_redirect_resp();
        test_double_redirect();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
